// File: rtl/regfile_mp.sv
// Multi-port register file: two write ports (port 1 wins), N bypassed read ports, zero-fill FSM.
// Optional pending-destination scoreboard enabled by defining REGFILE_SCOREBOARD_EN.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  output logic                     ready,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        waddr0,
  input  logic [DATA_W-1:0]        wdata0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        waddr1,
  input  logic [DATA_W-1:0]        wdata1,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic [NUM_RD-1:0]        busy
);

  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic {INIT, RUN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic                run, fill_wr, wr0, wr1;
  logic [ADDR_W-1:0]   addr_v;
  logic                hit0, hit1, zero_v;

  assign run   = (state_q == RUN);
  assign ready = run && !rst;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fill_wr = 1'b0;
    case (state_q)
      INIT: begin
        fill_wr = 1'b1;
        cnt_d   = cnt_q + ADDR_W'(1);
        if (cnt_q == ADDR_W'(DEPTH-1)) state_d = RUN;
      end
      RUN: begin
        if (clr) begin
          state_d = INIT;
          cnt_d   = '0;
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Entry 0 is never written when hardwired, so the fill leaves it at zero for good.
  assign wr0 = run && !clr && we0 && !((ZERO_REG != 0) && (waddr0 == '0));
  assign wr1 = run && !clr && we1 && !((ZERO_REG != 0) && (waddr1 == '0));

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (fill_wr) mem_q[cnt_q] <= '0;
      if (wr0)     mem_q[waddr0] <= wdata0;
      if (wr1)     mem_q[waddr1] <= wdata1;
    end
  end

`ifdef REGFILE_SCOREBOARD_EN
  logic [DEPTH-1:0] pend_q, pend_d;

  always_comb begin
    pend_d = pend_q;
    if (run && clr) begin
      pend_d = '0;
    end else if (run) begin
      if (wr0) pend_d[waddr0] = 1'b0;
      if (wr1) pend_d[waddr1] = 1'b0;
      // Issue applied after the write clears so a same-cycle set wins.
      if (iss_en && !((ZERO_REG != 0) && (iss_addr == '0))) pend_d[iss_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) pend_q <= '0;
    else     pend_q <= pend_d;
  end
`else
  logic unused_iss;
  assign unused_iss = ^{iss_en, iss_addr};
`endif

  always_comb begin
    rd_data = '0;
    busy    = '0;
    addr_v  = '0;
    hit0    = 1'b0;
    hit1    = 1'b0;
    zero_v  = 1'b0;
    for (int i = 0; i < NUM_RD; i++) begin
      addr_v = rd_addr[i*ADDR_W +: ADDR_W];
      hit0   = we0 && (waddr0 == addr_v);
      hit1   = we1 && (waddr1 == addr_v);
      zero_v = (ZERO_REG != 0) && (addr_v == '0);
      if (ready && rd_en[i] && !zero_v) begin
        if (hit1)      rd_data[i*DATA_W +: DATA_W] = wdata1;
        else if (hit0) rd_data[i*DATA_W +: DATA_W] = wdata0;
        else           rd_data[i*DATA_W +: DATA_W] = mem_q[addr_v];
`ifdef REGFILE_SCOREBOARD_EN
        busy[i] = pend_q[addr_v] && !hit0 && !hit1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: directed vector table, clr/reset fill sequences, random traffic vs a model.
module tb_regfile_mp;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int DEPTH = 32;

  logic            clk = 1'b0;
  logic            rst, clr, ready, we0, we1, iss_en;
  logic [AW-1:0]   waddr0, waddr1, iss_addr;
  logic [DW-1:0]   wdata0, wdata1;
  logic [NR-1:0]   rd_en, busy;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0]   mem [DEPTH];
  bit [DEPTH-1:0]  pend;
  bit              m_ready;
  int              fill_left;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .clr(clr), .ready(ready),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit we0; logic [AW-1:0] a0; logic [DW-1:0] d0;
    bit we1; logic [AW-1:0] a1; logic [DW-1:0] d1;
    bit iss; logic [AW-1:0] ia;
    logic [AW-1:0] r0; logic [AW-1:0] r1;
    logic [DW-1:0] e0; logic [DW-1:0] e1; bit eb0;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] m_rd(input int i);
    logic [AW-1:0] a;
    a = rd_addr[i*AW +: AW];
    if (!m_ready || rst || !rd_en[i] || a == 0) return '0;
    if (we1 && waddr1 == a) return wdata1;
    if (we0 && waddr0 == a) return wdata0;
    return mem[a];
  endfunction

  function automatic logic m_busy(input int i);
    logic [AW-1:0] a;
    a = rd_addr[i*AW +: AW];
`ifdef REGFILE_SCOREBOARD_EN
    return m_ready && !rst && rd_en[i] && a != 0 && pend[a]
           && !(we0 && waddr0 == a) && !(we1 && waddr1 == a);
`else
    return a != a;
`endif
  endfunction

  task automatic model_update();
    if (rst) begin
      m_ready = 0; fill_left = DEPTH; pend = '0;
    end else if (!m_ready) begin
      fill_left--;
      if (fill_left == 0) begin
        m_ready = 1;
        for (int k = 0; k < DEPTH; k++) mem[k] = '0;
      end
    end else if (clr) begin
      m_ready = 0; fill_left = DEPTH; pend = '0;
    end else begin
      if (we0 && waddr0 != 0) mem[waddr0] = wdata0;
      if (we1 && waddr1 != 0) mem[waddr1] = wdata1;
      if (we0) pend[waddr0] = 0;
      if (we1) pend[waddr1] = 0;
      if (iss_en && iss_addr != 0) pend[iss_addr] = 1;
    end
  endtask

  task automatic sample_check(input string tag);
    chk({tag, " ready"}, {31'd0, ready}, {31'd0, (m_ready && !rst)});
    for (int i = 0; i < NR; i++) begin
      chk($sformatf("%s rd%0d", tag, i), rd_data[i*DW +: DW], m_rd(i));
      chk($sformatf("%s busy%0d", tag, i), {31'd0, busy[i]}, {31'd0, m_busy(i)});
    end
  endtask

  task automatic edge_update();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic step(input string tag);
    @(negedge clk);
    sample_check(tag);
    edge_update();
  endtask

  task automatic idle();
    rst = 0; clr = 0; we0 = 0; we1 = 0; iss_en = 0;
    waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0; iss_addr = '0;
    rd_en = '1; rd_addr = '0;
  endtask

  task automatic wait_ready(input string tag);
    int k;
    k = 0;
    while (k < 100) begin
      step(tag);
      k++;
      if (ready) break;
    end
    chk({tag, " fill edges"}, k, DEPTH);
  endtask

  initial begin
    logic exp_b;
    for (int k = 0; k < DEPTH; k++) mem[k] = '0;
    pend = '0; m_ready = 0; fill_left = DEPTH;

    //            we0 a0  d0            we1 a1  d1            iss ia  r0  r1  e0            e1            eb0
    vecs[0]  = '{1, 5,  32'hDEADBEEF, 0, 0,  32'h0,        0, 0,  5,  7,  32'hDEADBEEF, 32'h0,        0};
    vecs[1]  = '{0, 0,  32'h0,        0, 0,  32'h0,        0, 0,  5,  7,  32'hDEADBEEF, 32'h0,        0};
    vecs[2]  = '{1, 7,  32'h11111111, 1, 7,  32'h22222222, 0, 0,  7,  5,  32'h22222222, 32'hDEADBEEF, 0};
    vecs[3]  = '{0, 0,  32'h0,        0, 0,  32'h0,        0, 0,  7,  0,  32'h22222222, 32'h0,        0};
    vecs[4]  = '{0, 0,  32'h0,        1, 0,  32'hFFFFFFFF, 1, 0,  0,  0,  32'h0,        32'h0,        0};
    vecs[5]  = '{0, 0,  32'h0,        0, 0,  32'h0,        0, 0,  0,  7,  32'h0,        32'h22222222, 0};
    vecs[6]  = '{0, 0,  32'h0,        0, 0,  32'h0,        1, 9,  9,  5,  32'h0,        32'hDEADBEEF, 0};
    vecs[7]  = '{0, 0,  32'h0,        0, 0,  32'h0,        0, 0,  9,  5,  32'h0,        32'hDEADBEEF, 1};
    vecs[8]  = '{1, 9,  32'h12345678, 0, 0,  32'h0,        0, 0,  9,  7,  32'h12345678, 32'h22222222, 0};
    vecs[9]  = '{0, 0,  32'h0,        0, 0,  32'h0,        0, 0,  9,  7,  32'h12345678, 32'h22222222, 0};
    vecs[10] = '{1, 9,  32'hCAFEF00D, 0, 0,  32'h0,        1, 9,  9,  7,  32'hCAFEF00D, 32'h22222222, 0};
    vecs[11] = '{0, 0,  32'h0,        0, 0,  32'h0,        0, 0,  9,  7,  32'hCAFEF00D, 32'h22222222, 1};
    vecs[12] = '{0, 0,  32'h0,        1, 3,  32'hA5A5A5A5, 0, 0,  3,  9,  32'hA5A5A5A5, 32'hCAFEF00D, 0};
    vecs[13] = '{0, 0,  32'h0,        0, 0,  32'h0,        0, 0,  3,  9,  32'hA5A5A5A5, 32'hCAFEF00D, 0};

    idle();
    rst = 1;
    step("rst");
    step("rst");
    rst = 0;
    wait_ready("init fill");

    for (int a = 0; a < DEPTH; a += 2) begin
      idle();
      rd_addr = {AW'(a + 1), AW'(a)};
      @(negedge clk);
      chk($sformatf("sweep r%0d", a), rd_data[DW-1:0], '0);
      chk($sformatf("sweep r%0d", a + 1), rd_data[2*DW-1:DW], '0);
      edge_update();
    end

    for (int v = 0; v < 14; v++) begin
      idle();
      we0 = vecs[v].we0; waddr0 = vecs[v].a0; wdata0 = vecs[v].d0;
      we1 = vecs[v].we1; waddr1 = vecs[v].a1; wdata1 = vecs[v].d1;
      iss_en = vecs[v].iss; iss_addr = vecs[v].ia;
      rd_addr = {vecs[v].r1, vecs[v].r0};
`ifdef REGFILE_SCOREBOARD_EN
      exp_b = vecs[v].eb0;
`else
      exp_b = 1'b0;
`endif
      @(negedge clk);
      chk($sformatf("vec%0d rd0", v), rd_data[DW-1:0], vecs[v].e0);
      chk($sformatf("vec%0d rd1", v), rd_data[2*DW-1:DW], vecs[v].e1);
      chk($sformatf("vec%0d busy0", v), {31'd0, busy[0]}, {31'd0, exp_b});
      sample_check($sformatf("vec%0d model", v));
      edge_update();
    end

    // clr while r3 holds data and r9 is pending
    idle();
    clr = 1;
    rd_addr = {AW'(9), AW'(3)};
    step("clr pulse");
    clr = 0;
    wait_ready("clr fill");
    @(negedge clk);
    chk("clr r3 data", rd_data[DW-1:0], '0);
    chk("clr r9 data", rd_data[2*DW-1:DW], '0);
    chk("clr r9 busy", {31'd0, busy[1]}, '0);
    edge_update();

    // reset at fill cycle 10 restarts the whole fill
    clr = 1;
    step("clr2 pulse");
    clr = 0;
    repeat (10) step("partial fill");
    rst = 1;
    step("mid-fill rst");
    rst = 0;
    wait_ready("refill");

    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      clr = ($urandom_range(0, 79) == 0);
      we0 = $urandom_range(0, 1) == 1;
      waddr0 = AW'($urandom_range(0, 7));
      wdata0 = $urandom;
      we1 = $urandom_range(0, 1) == 1;
      waddr1 = AW'($urandom_range(0, 7));
      wdata1 = $urandom;
      iss_en = ($urandom_range(0, 2) == 0);
      iss_addr = AW'($urandom_range(0, 7));
      rd_en = NR'($urandom_range(0, 3));
      rd_addr = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
      step("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port general-purpose register file for the CPU core; successor to the fixed 2R1W register file.
- Configurable data width, depth and read-port count; two write ports (port 1 = younger stage, wins conflicts); write-to-read bypass.
- Sequential zero-fill FSM after reset or on request, gated by a `ready` output.
- Optional scoreboard of pending destination registers for the issue stage.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
NUM_RD, 2, number of read ports, legal range 1..4
ZERO_REG, 1, 1 = entry 0 hardwired to zero (writes ignored, reads return 0, never busy)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
clr  in  1  request re-initialisation (zero-fill) while running
ready  out  1  1 = array initialised, accepting writes/issues
we0  in  1  write enable, port 0 (older stage)
waddr0  in  ADDR_W  write address, port 0
wdata0  in  DATA_W  write data, port 0
we1  in  1  write enable, port 1 (younger stage, priority)
waddr1  in  ADDR_W  write address, port 1
wdata1  in  DATA_W  write data, port 1
rd_en  in  NUM_RD  per-port read enable
rd_addr  in  NUM_RD*ADDR_W  packed read addresses, port i at [i*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  packed read data, combinational
iss_en  in  1  mark destination pending (scoreboard)
iss_addr  in  ADDR_W  destination being issued
busy  out  NUM_RD  per-read-port pending flag

Behaviour:
- Interface: one clock, `clk`. `rst` is synchronous and active-high.
- States: INIT, RUN. 5-bit-wide (ADDR_W) fill counter `cnt`.
- rst=1 at an edge: state<=INIT, cnt<=0, all pending bits <=0. While rst=1: ready=0, rd_data=0, busy=0.
- INIT, rst=0:
  - Each edge writes regs[cnt]<=0 and increments cnt.
  - When cnt==DEPTH-1 is written: state<=RUN.
  - ready goes 1 exactly DEPTH edges after the first edge with rst=0 (32 for defaults).
  - we0/we1/iss_en/clr ignored; rd_data=0; busy=0.
- Reset mid-INIT: cnt restarts at 0; full DEPTH-cycle fill repeats.
- RUN, clr=1 at an edge: state<=INIT, cnt<=0, pending<=0. Writes and issues in that same cycle are dropped.
- Writes (RUN):
  - weN=1 → regs[waddrN]<=wdataN.
  - Both ports, same address: wdata1 stored.
  - ZERO_REG=1 and address 0: write dropped.
- Reads (RUN), combinational per port i, in priority order:
  1. rd_en[i]=0 → 0.
  2. ZERO_REG and addr==0 → 0.
  3. we1 && waddr1==addr → wdata1.
  4. we0 && waddr0==addr → wdata0.
  5. Otherwise regs[addr].
- Read latency: 0 cycles; written data visible same cycle via bypass, next cycle from the array.
- Width rule: no sign or zero extension; addresses are always in range because DEPTH = 2**ADDR_W.

Optional Feature:
- Macro: REGFILE_SCOREBOARD_EN.
- Defined:
  - DEPTH-bit pending vector.
  - In RUN, iss_en=1 sets pending[iss_addr]; a write on either port clears pending[waddr].
  - Same-cycle set and clear of the same address: set wins.
  - iss_addr==0 with ZERO_REG is ignored.
  - busy[i] = rd_en[i] & pending[addr_i] & ~(same-cycle write to addr_i), and 0 for address 0 with ZERO_REG.
- Not defined: no pending storage; iss_en/iss_addr ignored; busy tied to 0.

Test Plan:
- Reset/fill: rst=1 for 2 cycles, then 0 → ready=0 for 32 edges, then 1; every address reads 0x00000000 once ready.
- Write/bypass: RUN, we0=1, waddr0=5, wdata0=0xDEADBEEF, rd_addr[0]=5 in the same cycle → rd_data[0]=0xDEADBEEF that cycle and all later cycles.
- Port priority: we0 to r7 with 0x11111111 and we1 to r7 with 0x22222222 in the same cycle → bypass and later read both return 0x22222222.
- Zero register: we1 to r0 with 0xFFFFFFFF → rd_addr=0 returns 0; with macro, iss_en to r0 → busy=0.
- Scoreboard (macro on):
  - iss_en to r9, read r9 next cycle → busy=1.
  - we0 to r9 in a later cycle → busy=0 that cycle.
  - Simultaneous iss_en r9 and we0 r9 → busy=1 next cycle.
- clr/reset mid-operation:
  - Write r3=0xA5A5A5A5, pulse clr → ready=0 for 32 cycles, r3 reads 0, pending cleared.
  - Assert rst at fill cycle 10 → fill restarts; ready 32 edges after rst falls.
